// File: rtl/core_pkg.sv
`default_nettype none
// ---------------------------------------------------------------
// core_pkg : shared encodings for the five-stage core control path
// Rev 1.0
// ---------------------------------------------------------------
package core_pkg;

  // Action taken by the pipeline controller in a cycle
  localparam logic [1:0] ST_RUN      = 2'd0;
  localparam logic [1:0] ST_STALL    = 2'd1;
  localparam logic [1:0] ST_REDIRECT = 2'd2;
  localparam logic [1:0] ST_FREEZE   = 2'd3;

  // EX operand source select
  localparam logic [1:0] FWD_RF    = 2'd0;
  localparam logic [1:0] FWD_EXMEM = 2'd1;
  localparam logic [1:0] FWD_MEMWB = 2'd2;

endpackage
`default_nettype wire

// File: rtl/sat_counter.sv
`default_nettype none
// ---------------------------------------------------------------
// sat_counter : event counter that sticks at its all-ones value
// Rev 1.0
// ---------------------------------------------------------------
module sat_counter #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc,
  output logic [W-1:0] count
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (inc && (count != {W{1'b1}})) begin
      count <= count + 1'b1;
    end
  end

endmodule
`default_nettype wire

// File: rtl/pipe_ctrl.sv
`default_nettype none
// ---------------------------------------------------------------
// pipe_ctrl : stall/flush/freeze control, EX forwarding selects, event counters
// Rev 1.0
// ---------------------------------------------------------------
module pipe_ctrl
  import core_pkg::*;
#(
  parameter int CNT_W = 32,
  parameter int RA_W  = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [RA_W-1:0]  id_rs1,
  input  logic [RA_W-1:0]  id_rs2,
  input  logic             id_use1,
  input  logic             id_use2,
  input  logic [RA_W-1:0]  ex_rd,
  input  logic             ex_wr,
  input  logic             ex_load,
  input  logic [RA_W-1:0]  mem_rd,
  input  logic             mem_wr,
  input  logic             ex_redirect,
  input  logic             dmem_busy,
  output logic             pc_we,
  output logic             ifid_we,
  output logic             ifid_flush,
  output logic             idex_we,
  output logic             idex_flush,
  output logic             exmem_we,
  output logic [1:0]       fwd_a,
  output logic [1:0]       fwd_b,
  output logic [1:0]       state,
  output logic [CNT_W-1:0] cnt_stall,
  output logic [CNT_W-1:0] cnt_flush
);

  logic       lu;
  logic [1:0] act;
  logic [1:0] fwd_a_nxt;
  logic [1:0] fwd_b_nxt;

  // The nearer producer (EX) takes precedence over MEM
  function automatic logic [1:0] fwd_sel(
    input logic [RA_W-1:0] rs,
    input logic [RA_W-1:0] e_rd,
    input logic            e_wr,
    input logic [RA_W-1:0] m_rd,
    input logic            m_wr
  );
    if ((rs != '0) && e_wr && (rs == e_rd)) begin
      return FWD_EXMEM;
    end else if ((rs != '0) && m_wr && (rs == m_rd)) begin
      return FWD_MEMWB;
    end
    return FWD_RF;
  endfunction

  assign lu = ex_load && ex_wr && (ex_rd != '0) &&
              ((id_use1 && (id_rs1 == ex_rd)) || (id_use2 && (id_rs2 == ex_rd)));

  assign fwd_a_nxt = fwd_sel(id_rs1, ex_rd, ex_wr, mem_rd, mem_wr);
  assign fwd_b_nxt = fwd_sel(id_rs2, ex_rd, ex_wr, mem_rd, mem_wr);

  always_comb begin
    if (dmem_busy) begin
      act = ST_FREEZE;
    end else if (ex_redirect) begin
      act = ST_REDIRECT;
    end else if (lu) begin
      act = ST_STALL;
    end else begin
      act = ST_RUN;
    end
  end

  always_comb begin
    pc_we      = 1'b1;
    ifid_we    = 1'b1;
    ifid_flush = 1'b0;
    idex_we    = 1'b1;
    idex_flush = 1'b0;
    exmem_we   = 1'b1;
    case (act)
      ST_FREEZE: begin
        pc_we    = 1'b0;
        ifid_we  = 1'b0;
        idex_we  = 1'b0;
        exmem_we = 1'b0;
      end
      ST_REDIRECT: begin
        ifid_flush = 1'b1;
        idex_flush = 1'b1;
      end
      ST_STALL: begin
        pc_we      = 1'b0;
        ifid_we    = 1'b0;
        idex_flush = 1'b1;
      end
      default: ;
    endcase
  end

  // Selects travel with the ID/EX register: bubbles carry no forwarding
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ST_RUN;
      fwd_a <= FWD_RF;
      fwd_b <= FWD_RF;
    end else begin
      state <= act;
      case (act)
        ST_RUN: begin
          fwd_a <= fwd_a_nxt;
          fwd_b <= fwd_b_nxt;
        end
        ST_FREEZE: ;
        default: begin
          fwd_a <= FWD_RF;
          fwd_b <= FWD_RF;
        end
      endcase
    end
  end

  sat_counter #(.W(CNT_W)) u_cnt_stall (
    .clk   (clk),
    .rst   (rst),
    .inc   (act == ST_STALL),
    .count (cnt_stall)
  );

  sat_counter #(.W(CNT_W)) u_cnt_flush (
    .clk   (clk),
    .rst   (rst),
    .inc   (act == ST_REDIRECT),
    .count (cnt_flush)
  );

endmodule
`default_nettype wire

// File: tb/tb_pipe_ctrl.sv
`default_nettype none
// ---------------------------------------------------------------
// tb_pipe_ctrl : directed vectors for pipe_ctrl (32-bit and 2-bit counter builds)
// Rev 1.0
// ---------------------------------------------------------------
module tb_pipe_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [4:0] id_rs1, id_rs2, ex_rd, mem_rd;
  logic       id_use1, id_use2, ex_wr, ex_load, mem_wr, ex_redirect, dmem_busy;

  logic        pc_we, ifid_we, ifid_flush, idex_we, idex_flush, exmem_we;
  logic [1:0]  fwd_a, fwd_b, state;
  logic [31:0] cnt_stall, cnt_flush;

  logic       s_pc_we, s_ifid_we, s_ifid_flush, s_idex_we, s_idex_flush, s_exmem_we;
  logic [1:0] s_fwd_a, s_fwd_b, s_state;
  logic [1:0] s_cnt_stall, s_cnt_flush;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  pipe_ctrl dut (
    .clk(clk), .rst(rst),
    .id_rs1(id_rs1), .id_rs2(id_rs2), .id_use1(id_use1), .id_use2(id_use2),
    .ex_rd(ex_rd), .ex_wr(ex_wr), .ex_load(ex_load),
    .mem_rd(mem_rd), .mem_wr(mem_wr),
    .ex_redirect(ex_redirect), .dmem_busy(dmem_busy),
    .pc_we(pc_we), .ifid_we(ifid_we), .ifid_flush(ifid_flush),
    .idex_we(idex_we), .idex_flush(idex_flush), .exmem_we(exmem_we),
    .fwd_a(fwd_a), .fwd_b(fwd_b), .state(state),
    .cnt_stall(cnt_stall), .cnt_flush(cnt_flush)
  );

  pipe_ctrl #(.CNT_W(2)) dut_s (
    .clk(clk), .rst(rst),
    .id_rs1(id_rs1), .id_rs2(id_rs2), .id_use1(id_use1), .id_use2(id_use2),
    .ex_rd(ex_rd), .ex_wr(ex_wr), .ex_load(ex_load),
    .mem_rd(mem_rd), .mem_wr(mem_wr),
    .ex_redirect(ex_redirect), .dmem_busy(dmem_busy),
    .pc_we(s_pc_we), .ifid_we(s_ifid_we), .ifid_flush(s_ifid_flush),
    .idex_we(s_idex_we), .idex_flush(s_idex_flush), .exmem_we(s_exmem_we),
    .fwd_a(s_fwd_a), .fwd_b(s_fwd_b), .state(s_state),
    .cnt_stall(s_cnt_stall), .cnt_flush(s_cnt_flush)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    id_rs1 = 0; id_rs2 = 0; id_use1 = 0; id_use2 = 0;
    ex_rd = 0; ex_wr = 0; ex_load = 0; mem_rd = 0; mem_wr = 0;
    ex_redirect = 0; dmem_busy = 0;
  endtask

  task automatic set_lu(input logic [4:0] r);
    idle();
    ex_load = 1; ex_wr = 1; ex_rd = r; id_rs1 = r; id_use1 = 1;
  endtask

  initial begin
    idle();
    #3;
    chk("rst_state", {30'd0, state}, 32'd0);
    chk("rst_fwd_a", {30'd0, fwd_a}, 32'd0);
    chk("rst_fwd_b", {30'd0, fwd_b}, 32'd0);
    chk("rst_cnt_stall", cnt_stall, 32'd0);
    chk("rst_cnt_flush", cnt_flush, 32'd0);
    chk("rst_run_en", {26'd0, pc_we, ifid_we, idex_we, exmem_we, ifid_flush, idex_flush}, 32'b111100);
    #9 rst = 1'b0;
    step();

    // Load-use: lw x5 in EX, ID reads x5
    set_lu(5'd5);
    #1;
    chk("lu_pc_we", {31'd0, pc_we}, 32'd0);
    chk("lu_ifid_we", {31'd0, ifid_we}, 32'd0);
    chk("lu_idex_flush", {31'd0, idex_flush}, 32'd1);
    chk("lu_exmem_we", {31'd0, exmem_we}, 32'd1);
    chk("lu_ifid_flush", {31'd0, ifid_flush}, 32'd0);
    step();
    chk("lu_state", {30'd0, state}, 32'd1);
    chk("lu_cnt_stall", cnt_stall, 32'd1);
    chk("lu_fwd_bubble", {30'd0, fwd_a}, 32'd0);
    idle();
    id_rs1 = 5; id_use1 = 1; mem_rd = 5; mem_wr = 1;
    #1;
    chk("lu_after_pc_we", {31'd0, pc_we}, 32'd1);
    chk("lu_after_flush", {31'd0, idex_flush}, 32'd0);
    step();
    chk("lu_after_state", {30'd0, state}, 32'd0);
    chk("lu_after_fwd_a", {30'd0, fwd_a}, 32'd2);

    // x0 destination and unused operand never stall
    idle();
    ex_load = 1; ex_wr = 1; ex_rd = 0; id_rs1 = 0; id_use1 = 1;
    #1;
    chk("x0_pc_we", {31'd0, pc_we}, 32'd1);
    step();
    chk("x0_fwd_a", {30'd0, fwd_a}, 32'd0);
    chk("x0_state", {30'd0, state}, 32'd0);
    idle();
    ex_load = 1; ex_wr = 1; ex_rd = 6; id_rs1 = 6; id_use1 = 0;
    #1;
    chk("unused_pc_we", {31'd0, pc_we}, 32'd1);
    chk("unused_idex_flush", {31'd0, idex_flush}, 32'd0);
    step();

    // Redirect wins over a simultaneous load-use
    set_lu(5'd5);
    ex_redirect = 1;
    #1;
    chk("rd_ifid_flush", {31'd0, ifid_flush}, 32'd1);
    chk("rd_idex_flush", {31'd0, idex_flush}, 32'd1);
    chk("rd_pc_we", {31'd0, pc_we}, 32'd1);
    chk("rd_ifid_we", {31'd0, ifid_we}, 32'd1);
    step();
    chk("rd_state", {30'd0, state}, 32'd2);
    chk("rd_cnt_flush", cnt_flush, 32'd1);
    chk("rd_cnt_stall", cnt_stall, 32'd1);
    chk("rd_fwd_a", {30'd0, fwd_a}, 32'd0);

    // Freeze holds a nonzero select while a redirect waits
    idle();
    ex_wr = 1; ex_rd = 9; id_rs1 = 9;
    step();
    chk("pre_frz_fwd_a", {30'd0, fwd_a}, 32'd1);
    idle();
    dmem_busy = 1; ex_redirect = 1;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("frz_en", {26'd0, pc_we, ifid_we, idex_we, exmem_we, ifid_flush, idex_flush}, 32'd0);
      step();
      chk("frz_fwd_a", {30'd0, fwd_a}, 32'd1);
      chk("frz_state", {30'd0, state}, 32'd3);
    end
    chk("frz_cnt_flush", cnt_flush, 32'd1);
    dmem_busy = 0;
    #1;
    chk("frz_rel_flush", {31'd0, ifid_flush}, 32'd1);
    step();
    chk("frz_rel_cnt_flush", cnt_flush, 32'd2);
    chk("frz_rel_s_cnt_flush", {30'd0, s_cnt_flush}, 32'd2);
    idle();
    step();

    // EX producer beats MEM producer; MEM alone gives 2
    idle();
    ex_rd = 7; mem_rd = 7; ex_wr = 1; mem_wr = 1; id_rs2 = 7;
    step();
    chk("prio_fwd_b", {30'd0, fwd_b}, 32'd1);
    ex_wr = 0;
    step();
    chk("mem_fwd_b", {30'd0, fwd_b}, 32'd2);

    // Five more stalls: 2-bit counter saturates at 3
    for (int i = 0; i < 5; i++) begin
      set_lu(5'd12);
      step();
      idle();
      step();
    end
    chk("sat_s_cnt_stall", {30'd0, s_cnt_stall}, 32'd3);
    chk("sat_cnt_stall", cnt_stall, 32'd6);

    // Async reset in the middle of a stall
    set_lu(5'd3);
    step();
    chk("pre_rst_state", {30'd0, s_state}, 32'd1);
    #2 rst = 1'b1;
    #1;
    chk("arst_s_cnt_stall", {30'd0, s_cnt_stall}, 32'd0);
    chk("arst_s_cnt_flush", {30'd0, s_cnt_flush}, 32'd0);
    chk("arst_cnt_stall", cnt_stall, 32'd0);
    chk("arst_state", {30'd0, state}, 32'd0);
    chk("arst_fwd", {28'd0, fwd_a, fwd_b}, 32'd0);
    chk("arst_comb_stall", {31'd0, pc_we}, 32'd0);
    idle();
    #10 rst = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire
